// File: rtl/ulpi_tx_arbiter.sv
// ulpi_tx_arbiter: owns the link-side transmit direction of the ULPI bus.
// Arbitrates between a register-write requester and a packet-transmit requester,
// sequences TX CMD / data / stp, and yields the bus immediately whenever dir rises.
// State advances only on ulpi_tick (one clk strobe per ULPI clock rising edge),
// except for the dir-triggered abort, which is taken on the next clk.
//
// Ports:
//   clk, n_rst                   system clock, asynchronous active-low reset
//   ulpi_tick                    one-clk strobe per ULPI clock rising edge
//   dir, nxt                     ULPI PHY handshake inputs
//   ulpi_data_out/_oe, stp       link-driven ULPI outputs
//   reg_req/addr/wdata           register-write request (addr/wdata latched at grant)
//   reg_done, reg_abort          1-clk registered completion / abort pulses
//   pkt_req/pid/byte/last        packet-transmit request (pid latched at grant)
//   pkt_byte_ack                 1-clk pulse: pkt_byte consumed
//   pkt_done, pkt_abort          1-clk registered completion / abort pulses
//   timeout_err                  1-clk pulse accompanying a timeout abort
module ulpi_tx_arbiter #(
    parameter int unsigned IDLE_GAP = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       ulpi_tick,
    input  logic       dir,
    input  logic       nxt,
    output logic [7:0] ulpi_data_out,
    output logic       ulpi_data_oe,
    output logic       stp,
    input  logic       reg_req,
    input  logic [5:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic       reg_done,
    output logic       reg_abort,
    input  logic       pkt_req,
    input  logic [3:0] pkt_pid,
    input  logic [7:0] pkt_byte,
    input  logic       pkt_last,
    output logic       pkt_byte_ack,
    output logic       pkt_done,
    output logic       pkt_abort,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        StIdle, StRegCmd, StRegData, StPktCmd, StPktData, StStop, StAbort, StGap
    } state_e;

    localparam logic [7:0] GapLast = 8'(IDLE_GAP);
    localparam logic [7:0] TmoLast = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic       grant_pkt_q, grant_pkt_d;  // current/last grantee; also the tie-break memory
    logic [5:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [3:0] pid_q, pid_d;
    logic [7:0] tmo_q, tmo_d, tmo_inc;
    logic [7:0] gap_q, gap_d, gap_inc;
    logic       go_abort;
    logic       reg_done_d, reg_abort_d, pkt_ack_d, pkt_done_d, pkt_abort_d, tmo_err_d;
    logic       drive;
    logic       stp_raw;
    logic [7:0] bus;

    always_comb begin
        state_d     = state_q;
        grant_pkt_d = grant_pkt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pid_d       = pid_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        tmo_inc     = tmo_q + 8'd1;
        gap_inc     = gap_q + 8'd1;
        go_abort    = 1'b0;
        reg_done_d  = 1'b0;
        reg_abort_d = 1'b0;
        pkt_ack_d   = 1'b0;
        pkt_done_d  = 1'b0;
        pkt_abort_d = 1'b0;
        tmo_err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (ulpi_tick && !dir && (reg_req || pkt_req)) begin
                    // On a tie the requester not served last wins.
                    if (reg_req && (!pkt_req || grant_pkt_q)) begin
                        grant_pkt_d = 1'b0;
                        addr_d      = reg_addr;
                        wdata_d     = reg_wdata;
                        state_d     = StRegCmd;
                    end else begin
                        grant_pkt_d = 1'b1;
                        pid_d       = pkt_pid;
                        state_d     = StPktCmd;
                    end
                    tmo_d = 8'd0;
                end
            end
            StRegCmd, StPktCmd: begin
                if (dir) begin
                    go_abort = 1'b1;
                end else if (ulpi_tick) begin
                    if (nxt) begin
                        state_d = (state_q == StRegCmd) ? StRegData : StPktData;
                    end else if (tmo_inc == TmoLast) begin
                        go_abort  = 1'b1;
                        tmo_err_d = 1'b1;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
            end
            StRegData: begin
                if (dir) begin
                    go_abort = 1'b1;
                end else if (ulpi_tick && nxt) begin
                    state_d = StStop;
                end
            end
            StPktData: begin
                if (dir) begin
                    go_abort = 1'b1;
                end else if (ulpi_tick && nxt) begin
                    pkt_ack_d = 1'b1;
                    if (pkt_last) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (dir) begin
                    go_abort = 1'b1;
                end else if (ulpi_tick) begin
                    reg_done_d = ~grant_pkt_q;
                    pkt_done_d = grant_pkt_q;
                    gap_d      = 8'd0;
                    state_d    = StGap;
                end
            end
            StAbort: begin
                if (ulpi_tick) begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (ulpi_tick) begin
                    gap_d = gap_inc;
                    if (gap_inc == GapLast) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // The abort pulse is issued on entry so it stays one clk wide while ABORT waits for a tick.
        if (go_abort) begin
            state_d     = StAbort;
            reg_abort_d = ~grant_pkt_q;
            pkt_abort_d = grant_pkt_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            grant_pkt_q  <= 1'b1;
            addr_q       <= 6'd0;
            wdata_q      <= 8'd0;
            pid_q        <= 4'd0;
            tmo_q        <= 8'd0;
            gap_q        <= 8'd0;
            reg_done     <= 1'b0;
            reg_abort    <= 1'b0;
            pkt_byte_ack <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_abort    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_pkt_q  <= grant_pkt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pid_q        <= pid_d;
            tmo_q        <= tmo_d;
            gap_q        <= gap_d;
            reg_done     <= reg_done_d;
            reg_abort    <= reg_abort_d;
            pkt_byte_ack <= pkt_ack_d;
            pkt_done     <= pkt_done_d;
            pkt_abort    <= pkt_abort_d;
            timeout_err  <= tmo_err_d;
        end
    end

    // Bus outputs are combinational so dir can strip oe/stp in the same clk.
    always_comb begin
        drive   = 1'b0;
        stp_raw = 1'b0;
        bus     = 8'h00;
        case (state_q)
            StRegCmd:  begin drive = 1'b1; bus = {2'b10, addr_q};   end
            StRegData: begin drive = 1'b1; bus = wdata_q;           end
            StPktCmd:  begin drive = 1'b1; bus = {4'b0100, pid_q};  end
            StPktData: begin drive = 1'b1; bus = pkt_byte;          end
            StStop:    begin drive = 1'b1; stp_raw = 1'b1;          end
            default:   begin drive = 1'b0;                          end
        endcase
        ulpi_data_oe  = drive & ~dir;
        ulpi_data_out = ulpi_data_oe ? bus : 8'h00;
        stp           = stp_raw & ~dir;
    end

endmodule

// File: tb/tb_ulpi_tx_arbiter.sv
// Self-checking bench for ulpi_tx_arbiter. The bench plays both requesters and the PHY;
// expected bus traffic is built as per-transaction byte lists from the ULPI framing rules.
module tb_ulpi_tx_arbiter;
    localparam int unsigned IDLE_GAP = 2;
    localparam int unsigned TIMEOUT  = 255;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       ulpi_tick = 1'b0;
    logic       dir = 1'b0;
    logic       nxt = 1'b0;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;
    logic       stp;
    logic       reg_req = 1'b0;
    logic [5:0] reg_addr = 6'd0;
    logic [7:0] reg_wdata = 8'd0;
    logic       reg_done, reg_abort;
    logic       pkt_req = 1'b0;
    logic [3:0] pkt_pid = 4'd0;
    logic [7:0] pkt_byte = 8'd0;
    logic       pkt_last = 1'b0;
    logic       pkt_byte_ack, pkt_done, pkt_abort, timeout_err;

    ulpi_tx_arbiter #(.IDLE_GAP(IDLE_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst), .ulpi_tick(ulpi_tick), .dir(dir), .nxt(nxt),
        .ulpi_data_out(ulpi_data_out), .ulpi_data_oe(ulpi_data_oe), .stp(stp),
        .reg_req(reg_req), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_done(reg_done), .reg_abort(reg_abort),
        .pkt_req(pkt_req), .pkt_pid(pkt_pid), .pkt_byte(pkt_byte), .pkt_last(pkt_last),
        .pkt_byte_ack(pkt_byte_ack), .pkt_done(pkt_done), .pkt_abort(pkt_abort),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int n_reg_done, n_reg_abort, n_pkt_done, n_pkt_abort, n_ack, n_tmo;
    logic [7:0] pkt_q[$];
    int         pkt_idx;
    logic [8:0] rec[$];     // accepted bus bytes, bit 8 = stp
    logic [8:0] exp_q[$];
    int         gap_meas;
    bit         last_pkt;   // model of the arbiter's tie-break memory
    logic       oe_s, stp_s;
    logic [7:0] d_s;
    int         cnt;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        n_reg_done = 0; n_reg_abort = 0; n_pkt_done = 0;
        n_pkt_abort = 0; n_ack = 0; n_tmo = 0;
    endtask

    // One clk; the requesters react to pulses and the bus invariants are checked.
    task automatic clk1(input logic t);
        ulpi_tick = t;
        @(posedge clk);
        #1;
        ulpi_tick = 1'b0;
        n_reg_done  += int'(reg_done);
        n_reg_abort += int'(reg_abort);
        n_pkt_done  += int'(pkt_done);
        n_pkt_abort += int'(pkt_abort);
        n_ack       += int'(pkt_byte_ack);
        n_tmo       += int'(timeout_err);
        if (pkt_byte_ack) begin
            pkt_idx++;
            if (pkt_idx < pkt_q.size()) begin
                pkt_byte = pkt_q[pkt_idx];
                pkt_last = (pkt_idx == pkt_q.size() - 1);
            end
        end
        if (reg_done || reg_abort) reg_req = 1'b0;
        if (pkt_done || pkt_abort) pkt_req = 1'b0;
        if (!ulpi_data_oe) chk("data_zero_without_oe", ulpi_data_out, 0);
        if (dir) chk("no_stp_with_dir", stp, 0);
    endtask

    // One ULPI clock period (4 clks); returns the bus as the PHY saw it at that edge.
    task automatic utick(input logic nxt_v, output logic o, output logic s, output logic [7:0] d);
        nxt = nxt_v;
        o = ulpi_data_oe;
        s = stp;
        d = ulpi_data_out;
        clk1(1'b1);
        clk1(1'b0);
        clk1(1'b0);
        clk1(1'b0);
    endtask

    task automatic load_pkt(input logic [3:0] pid);
        pkt_pid  = pid;
        pkt_idx  = 0;
        pkt_byte = pkt_q[0];
        pkt_last = (pkt_q.size() == 1);
        pkt_req  = 1'b1;
    endtask

    task automatic req_reg(input logic [5:0] a, input logic [7:0] w);
        reg_addr  = a;
        reg_wdata = w;
        reg_req   = 1'b1;
    endtask

    task automatic plan_reg(input logic [5:0] a, input logic [7:0] w);
        exp_q.push_back({1'b0, 2'b10, a});
        exp_q.push_back({1'b0, w});
        exp_q.push_back(9'h100);
        last_pkt = 1'b0;
    endtask

    task automatic plan_pkt(input logic [3:0] p);
        exp_q.push_back({1'b0, 4'b0100, p});
        foreach (pkt_q[i]) exp_q.push_back({1'b0, pkt_q[i]});
        exp_q.push_back(9'h100);
        last_pkt = 1'b1;
    endtask

    task automatic plan_both(input logic [5:0] a, input logic [7:0] w, input logic [3:0] p);
        if (last_pkt) begin
            plan_reg(a, w);
            plan_pkt(p);
        end else begin
            plan_pkt(p);
            plan_reg(a, w);
        end
    endtask

    // PHY model: nxt rises lat ticks after the link starts driving. Ends when both requests are
    // gone and the bus has been idle through the gap and the arbitration tick.
    task automatic run_bus(input int lat, input int max_ticks);
        int   oe_run = 0;
        int   gap = 0;
        bit   seen_stp = 0;
        bit   finished = 0;
        logic nv, o, s;
        logic [7:0] d;
        rec.delete();
        gap_meas = -1;
        for (int k = 0; k < max_ticks; k++) begin
            nv = ulpi_data_oe && (oe_run >= lat);
            utick(nv, o, s, d);
            if (o) begin
                if (seen_stp) begin
                    gap_meas = gap;
                    seen_stp = 0;
                end
                gap = 0;
                oe_run++;
                if (nv || s) rec.push_back({s, d});
                if (s) seen_stp = 1;
            end else begin
                oe_run = 0;
                gap++;
            end
            if (!reg_req && !pkt_req && gap > int'(IDLE_GAP)) begin
                finished = 1;
                break;
            end
        end
        chk("run_bus_finished", 32'(finished), 1);
    endtask

    task automatic cmp_rec(input string tag);
        chk($sformatf("%s_len", tag), rec.size(), exp_q.size());
        for (int i = 0; i < rec.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(rec[i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    initial begin
        logic [5:0] ra;
        logic [7:0] rw;
        logic [3:0] rp;
        int         mode, lat, nb;

        clr_cnt();
        last_pkt = 1'b1;
        repeat (3) clk1(1'b0);
        chk("reset_oe", ulpi_data_oe, 0);
        chk("reset_data", ulpi_data_out, 0);
        chk("reset_stp", stp, 0);
        chk("reset_pulses",
            {reg_done, reg_abort, pkt_done, pkt_abort, pkt_byte_ack, timeout_err}, 0);
        n_rst = 1'b1;
        clk1(1'b0);

        // Tie straight after reset: register write first, then packet.
        clr_cnt();
        pkt_q = '{8'h01, 8'h02};
        req_reg(6'h0A, 8'h55);
        load_pkt(4'h1);
        plan_both(6'h0A, 8'h55, 4'h1);
        run_bus(1, 100);
        cmp_rec("tie_from_reset");
        chk("tie_gap_ticks", gap_meas, IDLE_GAP + 1);  // GAP ticks plus the arbitration tick
        chk("tie_reg_done", n_reg_done, 1);
        chk("tie_pkt_done", n_pkt_done, 1);

        // Register write 0x0A/0x55, nxt from the 2nd tick.
        clr_cnt();
        req_reg(6'h0A, 8'h55);
        plan_reg(6'h0A, 8'h55);
        run_bus(1, 60);
        cmp_rec("reg_write");
        chk("reg_write_done", n_reg_done, 1);
        chk("reg_write_no_pkt", n_pkt_done + n_pkt_abort + n_reg_abort, 0);

        // Repeated tie after a register write: packet goes first.
        clr_cnt();
        pkt_q = '{8'h5A};
        req_reg(6'h3F, 8'h81);
        load_pkt(4'hE);
        plan_both(6'h3F, 8'h81, 4'hE);
        run_bus(0, 100);
        cmp_rec("tie_repeat");

        // Packet PID 3, bytes AA BB CC.
        clr_cnt();
        pkt_q = '{8'hAA, 8'hBB, 8'hCC};
        load_pkt(4'h3);
        plan_pkt(4'h3);
        run_bus(0, 60);
        cmp_rec("pkt_tx");
        chk("pkt_tx_acks", n_ack, 3);
        chk("pkt_tx_done", n_pkt_done, 1);
        chk("pkt_tx_no_abort", n_pkt_abort, 0);

        // dir rises during PKT_DATA.
        clr_cnt();
        pkt_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_pkt(4'h5);
        repeat (3) utick(1'b1, oe_s, stp_s, d_s);
        chk("dir_pre_oe", ulpi_data_oe, 1);
        #2 dir = 1'b1;
        #1;
        chk("dir_oe_same_clk", ulpi_data_oe, 0);
        chk("dir_data_same_clk", ulpi_data_out, 0);
        chk("dir_stp_same_clk", stp, 0);
        repeat (4) begin
            utick(1'b0, oe_s, stp_s, d_s);
            chk("dir_hold_oe", oe_s, 0);
        end
        chk("dir_pkt_abort", n_pkt_abort, 1);
        chk("dir_no_done", n_pkt_done + n_reg_done + n_reg_abort, 0);
        last_pkt = 1'b1;
        load_pkt(4'h5);
        repeat (3) begin
            utick(1'b0, oe_s, stp_s, d_s);
            chk("dir_idle_wait_oe", oe_s, 0);
        end
        dir = 1'b0;
        plan_pkt(4'h5);
        run_bus(0, 60);
        cmp_rec("dir_regrant");

        // nxt held low in REG_CMD until the timeout fires.
        clr_cnt();
        req_reg(6'h21, 8'hC3);
        cnt = 0;
        for (int k = 0; k < 300 && reg_req; k++) begin
            utick(1'b0, oe_s, stp_s, d_s);
            if (oe_s) cnt++;
        end
        chk("tmo_oe_ticks", cnt, TIMEOUT);
        chk("tmo_reg_abort", n_reg_abort, 1);
        chk("tmo_err", n_tmo, 1);
        chk("tmo_no_done", n_reg_done, 0);
        chk("tmo_oe_after", ulpi_data_oe, 0);
        last_pkt = 1'b0;
        repeat (2) utick(1'b0, oe_s, stp_s, d_s);

        // Reset asserted mid-PKT_DATA.
        clr_cnt();
        pkt_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        load_pkt(4'h9);
        repeat (3) utick(1'b1, oe_s, stp_s, d_s);
        chk("rst_pre_oe", ulpi_data_oe, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_oe", ulpi_data_oe, 0);
        chk("rst_stp", stp, 0);
        chk("rst_data", ulpi_data_out, 0);
        repeat (3) clk1(1'b0);
        chk("rst_no_pulse", n_pkt_done + n_pkt_abort + n_reg_done + n_reg_abort, 0);
        #2 n_rst = 1'b1;
        clk1(1'b0);
        last_pkt = 1'b1;
        load_pkt(4'h9);
        plan_pkt(4'h9);
        run_bus(2, 80);
        cmp_rec("rst_regrant");

        // Randomised mix of single and contending requests.
        for (int r = 0; r < 16; r++) begin
            clr_cnt();
            mode = int'($urandom_range(0, 2));
            lat  = int'($urandom_range(0, 3));
            ra   = 6'($urandom_range(0, 63));
            rw   = 8'($urandom_range(0, 255));
            rp   = 4'($urandom_range(0, 15));
            nb   = int'($urandom_range(1, 4));
            pkt_q.delete();
            repeat (nb) pkt_q.push_back(8'($urandom_range(0, 255)));
            if (mode != 1) req_reg(ra, rw);
            if (mode != 0) load_pkt(rp);
            case (mode)
                0:       plan_reg(ra, rw);
                1:       plan_pkt(rp);
                default: plan_both(ra, rw, rp);
            endcase
            run_bus(lat, 200);
            cmp_rec($sformatf("rand%0d", r));
            chk("rand_reg_done", n_reg_done, (mode != 1) ? 1 : 0);
            chk("rand_pkt_done", n_pkt_done, (mode != 0) ? 1 : 0);
            chk("rand_acks", n_ack, (mode != 0) ? nb : 0);
            chk("rand_no_abort", n_reg_abort + n_pkt_abort + n_tmo, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
